// File: rtl/pulse_gen_multi_if.sv
// Control/config bundle and pulse outputs of the multi-channel pulse generator.
// The controller side drives configuration; the generator side returns pulses and status.
interface pulse_gen_multi_if #(
  parameter int CNT_W  = 16,
  parameter int NUM_CH = 2
);
  logic                    en;
  logic                    mode;
  logic                    trig;
  logic [7:0]              burst_len;
  logic [CNT_W-1:0]        period;
  logic [NUM_CH*CNT_W-1:0] delay;
  logic [NUM_CH*CNT_W-1:0] width;
  logic                    cfg_load;
  logic [NUM_CH-1:0]       pulse_out;
  logic                    frame_start;
  logic                    busy;

  modport master (
    output en, mode, trig, burst_len, period, delay, width, cfg_load,
    input  pulse_out, frame_start, busy
  );

  modport slave (
    input  en, mode, trig, burst_len, period, delay, width, cfg_load,
    output pulse_out, frame_start, busy
  );
endinterface

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: one shared period counter, per-channel delay/width,
// continuous or triggered-burst operation, config shadowed and applied on period boundaries.
module pulse_gen_multi #(
  parameter int CNT_W      = 16,
  parameter int NUM_CH     = 2,
  parameter int DEF_PERIOD = 5000,
  parameter int DEF_WIDTH  = 1000
) (
  input  logic              clk,
  input  logic              rst,
  pulse_gen_multi_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [7:0]              bursts_left;
  logic                    pending;
  logic [CNT_W-1:0]        shd_period;
  logic [NUM_CH*CNT_W-1:0] shd_delay;
  logic [NUM_CH*CNT_W-1:0] shd_width;
  logic [CNT_W-1:0]        act_period;
  logic [NUM_CH*CNT_W-1:0] act_delay;
  logic [NUM_CH*CNT_W-1:0] act_width;
  logic [NUM_CH-1:0]       pulse_q;
  logic [NUM_CH-1:0]       hit;
  logic                    wrap;
  logic                    apply;

  function automatic logic [CNT_W-1:0] sat_period(input logic [CNT_W-1:0] p);
    return (p < CNT_W'(2)) ? CNT_W'(2) : p;
  endfunction

  // Sum kept one bit wider so a large width cannot wrap below the delay.
  function automatic logic [CNT_W:0] pulse_end(input logic [CNT_W-1:0] d,
                                               input logic [CNT_W-1:0] w,
                                               input logic [CNT_W-1:0] p);
    logic [CNT_W:0] s;
    s = {1'b0, d} + {1'b0, w};
    return (s > {1'b0, p}) ? {1'b0, p} : s;
  endfunction

  assign wrap  = (state == RUN) && (cnt >= act_period - CNT_W'(1));
  assign apply = pending && ((state == IDLE) || wrap);

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = (cnt >= act_delay[i*CNT_W +: CNT_W]) &&
               ({1'b0, cnt} < pulse_end(act_delay[i*CNT_W +: CNT_W],
                                        act_width[i*CNT_W +: CNT_W], act_period));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bursts_left <= '0;
      pending     <= 1'b0;
      shd_period  <= CNT_W'(DEF_PERIOD);
      shd_delay   <= '0;
      shd_width   <= {NUM_CH{CNT_W'(DEF_WIDTH)}};
      act_period  <= CNT_W'(DEF_PERIOD);
      act_delay   <= '0;
      act_width   <= {NUM_CH{CNT_W'(DEF_WIDTH)}};
      pulse_q     <= '0;
    end else begin
      if (bus.cfg_load) begin
        shd_period <= bus.period;
        shd_delay  <= bus.delay;
        shd_width  <= bus.width;
      end
      // A load coinciding with an apply keeps pending set for the next boundary.
      if (bus.cfg_load)
        pending <= 1'b1;
      else if (apply)
        pending <= 1'b0;
      if (apply) begin
        act_period <= sat_period(shd_period);
        act_delay  <= shd_delay;
        act_width  <= shd_width;
      end

      pulse_q <= (state == RUN) ? hit : '0;

      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.en && !bus.mode) begin
            state <= RUN;
          end else if (bus.en && bus.mode && bus.trig) begin
            state       <= RUN;
            bursts_left <= (bus.burst_len == 8'd0) ? 8'd1 : bus.burst_len;
          end
        end
        RUN: begin
          if (wrap) begin
            cnt <= '0;
            if (!bus.mode) begin
              if (!bus.en) state <= IDLE;
            end else begin
              bursts_left <= bursts_left - 8'd1;
              if ((bursts_left <= 8'd1) || !bus.en) state <= IDLE;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.pulse_out   = pulse_q;
  assign bus.frame_start = (state == RUN) && (cnt == '0);
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: table of per-period timing vectors plus
// hand-written sequences for mid-period reload, bursts, en drop and async reset.
module tb_pulse_gen_multi;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pulse_gen_multi_if #(.CNT_W(16), .NUM_CH(2)) bus ();

  pulse_gen_multi #(
    .CNT_W(16), .NUM_CH(2), .DEF_PERIOD(5000), .DEF_WIDTH(1000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int load;
    int p, d0, w0, d1, w1;
    int ep, hi0, r0, hi1, r1;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic wait_frame(input int limit);
    int n;
    n = 0;
    while (!bus.frame_start && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (!bus.frame_start) check("frame_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (bus.busy && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) check("idle_timeout", 0, 1);
  endtask

  task automatic load_cfg(input int p, input int d0, input int w0, input int d1, input int w1);
    bus.period = 16'(p);
    bus.delay  = {16'(d1), 16'(d0)};
    bus.width  = {16'(w1), 16'(w0)};
    @(negedge clk);
    bus.cfg_load = 1'b1;
    @(negedge clk);
    bus.cfg_load = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Called on the frame_start cycle (k=0); samples k=1..p.
  task automatic measure(input int p, input int load_k,
                         output int hi0, output int r0, output int hi1, output int r1,
                         output int fpos);
    hi0 = 0; r0 = 0; hi1 = 0; r1 = 0; fpos = 0;
    for (int k = 1; k <= p; k++) begin
      @(negedge clk);
      if (bus.pulse_out[0]) begin hi0++; if (r0 == 0) r0 = k; end
      if (bus.pulse_out[1]) begin hi1++; if (r1 == 0) r1 = k; end
      if (bus.frame_start && fpos == 0) fpos = k;
      bus.cfg_load = (k == load_k);
    end
    bus.cfg_load = 1'b0;
  endtask

  initial begin
    int hi0, r0, hi1, r1, fpos;
    int frames, e0, e1;
    logic [1:0] prev;

    total = 0;
    bad   = 0;
    tbl[0] = '{0,   0,  0,  0,  0,     0, 5000, 1000,  1, 1000,  1};
    tbl[1] = '{1,  10,  8,  5,  0,    10,   10,    2,  9,   10,  1};
    tbl[2] = '{1,  10,  2,  0, 12,     3,   10,    0,  0,    0,  0};
    tbl[3] = '{1,   1,  0,  1,  1,     1,    2,    1,  1,    1,  2};
    tbl[4] = '{1, 100, 20, 30, 95,    10,  100,   30, 21,    5, 96};
    tbl[5] = '{1,  10,  0,  5,  3, 65535,   10,    5,  1,    7,  4};

    rst = 1'b0;
    bus.en = 1'b0; bus.mode = 1'b0; bus.trig = 1'b0; bus.burst_len = 8'd0;
    bus.period = '0; bus.delay = '0; bus.width = '0; bus.cfg_load = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_pulse", int'(bus.pulse_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_frame", int'(bus.frame_start), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      bus.en = 1'b0;
      wait_idle(6000);
      if (tbl[v].load != 0) load_cfg(tbl[v].p, tbl[v].d0, tbl[v].w0, tbl[v].d1, tbl[v].w1);
      bus.mode = 1'b0;
      bus.en   = 1'b1;
      wait_frame(20);
      measure(tbl[v].ep, 0, hi0, r0, hi1, r1, fpos);
      check($sformatf("v%0d_hi0", v), hi0, tbl[v].hi0);
      check($sformatf("v%0d_rise0", v), r0, tbl[v].r0);
      check($sformatf("v%0d_hi1", v), hi1, tbl[v].hi1);
      check($sformatf("v%0d_rise1", v), r1, tbl[v].r1);
      check($sformatf("v%0d_period", v), fpos, tbl[v].ep);
    end

    // Mid-period reload: old 5000-clock timing finishes, then the new one applies.
    bus.en = 1'b0;
    wait_idle(6000);
    load_cfg(5000, 0, 1000, 0, 1000);
    bus.period = 16'd100;
    bus.delay  = {16'd20, 16'd0};
    bus.width  = {16'd30, 16'd10};
    bus.en = 1'b1;
    wait_frame(20);
    measure(5000, 100, hi0, r0, hi1, r1, fpos);
    check("mid_old_hi0", hi0, 1000);
    check("mid_old_period", fpos, 5000);
    measure(100, 0, hi0, r0, hi1, r1, fpos);
    check("mid_new_hi0", hi0, 10);
    check("mid_new_hi1", hi1, 30);
    check("mid_new_rise1", r1, 21);
    check("mid_new_period", fpos, 100);

    // Burst of 3 with a stray trig mid-burst.
    bus.en = 1'b0;
    wait_idle(200);
    load_cfg(10, 0, 5, 3, 2);
    bus.mode = 1'b1; bus.burst_len = 8'd3; bus.en = 1'b1;
    repeat (3) @(negedge clk);
    check("burst_no_trig_busy", int'(bus.busy), 0);
    bus.trig = 1'b1;
    frames = 0; e0 = 0; e1 = 0; prev = 2'b00;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      bus.trig = (i == 12);
      if (bus.frame_start) frames++;
      if (bus.pulse_out[0] && !prev[0]) e0++;
      if (bus.pulse_out[1] && !prev[1]) e1++;
      prev = bus.pulse_out;
    end
    check("burst_frames", frames, 3);
    check("burst_edges0", e0, 3);
    check("burst_edges1", e1, 3);
    check("burst_end_busy", int'(bus.busy), 0);

    bus.burst_len = 8'd0;
    bus.trig = 1'b1;
    frames = 0; e0 = 0; prev = 2'b00;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      bus.trig = 1'b0;
      if (bus.frame_start) frames++;
      if (bus.pulse_out[0] && !prev[0]) e0++;
      prev = bus.pulse_out;
    end
    check("burst0_frames", frames, 1);
    check("burst0_edges0", e0, 1);

    // trig with en low in IDLE must not start.
    bus.en = 1'b0; bus.trig = 1'b1;
    @(negedge clk);
    bus.trig = 1'b0;
    repeat (3) @(negedge clk);
    check("trig_en_low_busy", int'(bus.busy), 0);

    // en dropped at cnt=3: pulse completes, period ends, then IDLE.
    bus.mode = 1'b0; bus.en = 1'b1;
    wait_frame(20);
    hi0 = 0; frames = 0;
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      if (bus.pulse_out[0]) hi0++;
      if (bus.frame_start) frames++;
      if (k == 9)  check("endrop_busy_k9", int'(bus.busy), 1);
      if (k == 10) check("endrop_busy_k10", int'(bus.busy), 0);
      if (k == 11) check("endrop_pulse_k11", int'(bus.pulse_out), 0);
      if (k == 3) bus.en = 1'b0;
    end
    check("endrop_hi0", hi0, 5);
    check("endrop_frames", frames, 0);

    // Asynchronous reset mid-pulse, then defaults restored.
    bus.en = 1'b1;
    wait_frame(20);
    @(negedge clk);
    @(negedge clk);
    check("arst_pre_pulse0", int'(bus.pulse_out[0]), 1);
    #2 rst = 1'b0;
    #1;
    check("arst_pulse", int'(bus.pulse_out), 0);
    check("arst_busy", int'(bus.busy), 0);
    @(negedge clk);
    rst = 1'b1;
    wait_frame(20);
    measure(5000, 0, hi0, r0, hi1, r1, fpos);
    check("arst_def_hi0", hi0, 1000);
    check("arst_def_rise0", r0, 1);
    check("arst_def_hi1", hi1, 1000);
    check("arst_def_period", fpos, 5000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
